// File: rtl/caxi4interconnect_reset_pkg.sv
// Shared definitions for the interconnect reset sequencer.
//   seq_state_e  : sequencer state encoding (IDLE / QUIESCE / HOLD / RELEASE)
//   DOM_ASSERT   : level that holds a domain in reset (domain resets are active-low)
//   DOM_DEASSERT : level that releases a domain
//   clog2()      : ceiling log2, used to size the shared timer
package caxi4interconnect_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } seq_state_e;

  localparam logic DOM_ASSERT   = 1'b0;
  localparam logic DOM_DEASSERT = 1'b1;

  // Number of bits needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int v;
    int n;
    n = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/caxi4interconnect_reset_seq_timer.sv
// Loadable down-counter with a terminal-count flag, shared by the quiesce
// timeout, the hold time and the release stage gap.
//   clk      : clock
//   rst      : synchronous active-high reset, presets the count to RST_VAL
//   load     : load load_val this cycle (has priority over counting)
//   load_val : value to load; loading N-1 makes tc rise N cycles later
//   tc       : count is zero (terminal count); the counter then holds at zero
module caxi4interconnect_reset_seq_timer #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/caxi4interconnect_reset_sequencer.sv
// Issues the staged active-low per-domain resets of the interconnect.
// A soft-reset request first asks the crossbar to quiesce (bounded by a
// timeout), then all domains are held in reset for HOLD_CYCLES and released
// one at a time, bit 0 first, STAGE_GAP cycles apart. The same hold/release
// sequence runs after sysReset, without the quiesce phase.
//   sysClk      : clock
//   sysReset    : synchronous active-high reset
//   softRstReq  : soft-reset request level, only looked at in IDLE
//   quiesceAck  : crossbar drained, only looked at in QUIESCE
//   quiesceReq  : ask the crossbar to stop accepting and drain
//   domReset_L  : active-low reset per domain
//   seqBusy     : sequence in progress
//   seqDone     : one-cycle pulse with the last domain release
//   timeoutErr  : one-cycle pulse when the quiesce wait timed out
// All outputs come straight from flops.
module caxi4interconnect_reset_sequencer
  import caxi4interconnect_reset_pkg::*;
#(
  parameter int NUM_DOMAINS     = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter int QUIESCE_TIMEOUT = 256
) (
  input  logic                   sysClk,
  input  logic                   sysReset,
  input  logic                   softRstReq,
  input  logic                   quiesceAck,
  output logic                   quiesceReq,
  output logic [NUM_DOMAINS-1:0] domReset_L,
  output logic                   seqBusy,
  output logic                   seqDone,
  output logic                   timeoutErr
);

  if (NUM_DOMAINS < 1) begin : g_bad_num_domains
    $error("NUM_DOMAINS must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("HOLD_CYCLES must be at least 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_stage_gap
    $error("STAGE_GAP must be at least 1");
  end
  if (QUIESCE_TIMEOUT < 1) begin : g_bad_quiesce_timeout
    $error("QUIESCE_TIMEOUT must be at least 1");
  end

  localparam int CNT_MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_MAX    = (CNT_MAX_HG > QUIESCE_TIMEOUT) ? CNT_MAX_HG : QUIESCE_TIMEOUT;
  localparam int CNT_W      = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);

  // Timer loads are N-1: terminal count is reached in the N-th cycle of a phase.
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] QUIESCE_LD = CNT_W'(QUIESCE_TIMEOUT - 1);

  localparam logic [NUM_DOMAINS-1:0] DOM_ALL_ASSERTED = {NUM_DOMAINS{DOM_ASSERT}};
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL_RELEASED = {NUM_DOMAINS{DOM_DEASSERT}};

  seq_state_e             state_q, state_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   qreq_q, qreq_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   terr_q, terr_d;

  logic                   tmr_load;
  logic [CNT_W-1:0]       tmr_val;
  logic                   tmr_tc;
  logic [NUM_DOMAINS-1:0] rel_next;

  // Reset preloads the hold count, so the power-on hold starts in the first
  // cycle after sysReset drops.
  caxi4interconnect_reset_seq_timer #(
    .WIDTH   (CNT_W),
    .RST_VAL (HOLD_LD)
  ) u_timer (
    .clk      (sysClk),
    .rst      (sysReset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Release pattern after one more stage: shift a released level in at bit 0.
  // From the all-asserted hold pattern this releases bit 0 only.
  assign rel_next = (dom_q << 1) | NUM_DOMAINS'(DOM_DEASSERT);

  always_comb begin
    state_d  = state_q;
    dom_d    = dom_q;
    qreq_d   = qreq_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    terr_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LD;

    case (state_q)
      ST_IDLE: begin
        if (softRstReq) begin
          state_d  = ST_QUIESCE;
          qreq_d   = 1'b1;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = QUIESCE_LD;
        end
      end

      ST_QUIESCE: begin
        // An ack in the very last timeout cycle still counts as an ack.
        if (quiesceAck || tmr_tc) begin
          state_d  = ST_HOLD;
          dom_d    = DOM_ALL_ASSERTED;
          terr_d   = !quiesceAck;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end

      // The end of HOLD and each stage of RELEASE do the same thing: release
      // one more domain, and finish once the last one is out.
      ST_HOLD, ST_RELEASE: begin
        if (tmr_tc) begin
          dom_d = rel_next;
          if (rel_next == DOM_ALL_RELEASED) begin
            state_d = ST_IDLE;
            qreq_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_RELEASE;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end
        end
      end

      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q <= ST_HOLD;
      dom_q   <= DOM_ALL_ASSERTED;
      qreq_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dom_q   <= dom_d;
      qreq_q  <= qreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  assign quiesceReq = qreq_q;
  assign domReset_L = dom_q;
  assign seqBusy    = busy_q;
  assign seqDone    = done_q;
  assign timeoutErr = terr_q;

endmodule

// File: tb/tb_caxi4interconnect_reset_sequencer.sv
// Scoreboard bench: the stimulus pushes every expected output change
// (cycle number + output vector) into a queue per DUT; a monitor per DUT
// detects each change of the outputs and compares it against the queue head.
// Vector layout: {quiesceReq, domReset_L[3:0], seqBusy, seqDone, timeoutErr}.
module tb_caxi4interconnect_reset_sequencer;

  logic       sysClk;
  logic       sysReset;
  logic       softRstReq, quiesceAck;
  logic       soft2, ack2;

  logic       quiesceReq, seqBusy, seqDone, timeoutErr;
  logic [3:0] domReset_L;
  logic       qreq2, busy2, done2, terr2;
  logic [0:0] dom2;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
    string      name;
  } ev_t;

  ev_t exp1[$];
  ev_t exp2[$];

  caxi4interconnect_reset_sequencer dut4 (
    .sysClk     (sysClk),
    .sysReset   (sysReset),
    .softRstReq (softRstReq),
    .quiesceAck (quiesceAck),
    .quiesceReq (quiesceReq),
    .domReset_L (domReset_L),
    .seqBusy    (seqBusy),
    .seqDone    (seqDone),
    .timeoutErr (timeoutErr)
  );

  caxi4interconnect_reset_sequencer #(
    .NUM_DOMAINS (1),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (1)
  ) dut1 (
    .sysClk     (sysClk),
    .sysReset   (sysReset),
    .softRstReq (soft2),
    .quiesceAck (ack2),
    .quiesceReq (qreq2),
    .domReset_L (dom2),
    .seqBusy    (busy2),
    .seqDone    (done2),
    .timeoutErr (terr2)
  );

  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  always @(posedge sysClk) cyc <= cyc + 1;

  function automatic logic [7:0] pack(logic q, logic [3:0] d, logic b, logic dn, logic te);
    return {q, d, b, dn, te};
  endfunction

  task automatic check_ev(string name, int got_c, logic [7:0] got_v, int exp_c, logic [7:0] exp_v);
    checks++;
    if (got_c != exp_c || got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got cycle %0d vec %b, required cycle %0d vec %b",
               name, got_c, got_v, exp_c, exp_v);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic ev1(int c, string n, logic q, logic [3:0] d, logic b, logic dn, logic te);
    ev_t e;
    e.cyc = c; e.vec = pack(q, d, b, dn, te); e.name = n;
    exp1.push_back(e);
  endtask

  task automatic ev2(int c, string n, logic q, logic d, logic b, logic dn, logic te);
    ev_t e;
    e.cyc = c; e.vec = pack(q, {3'b000, d}, b, dn, te); e.name = n;
    exp2.push_back(e);
  endtask

  // Release phase of the 4-domain DUT starting at cycle h (first release).
  task automatic push_release(int h, logic qv, logic retrig);
    ev1(h,      "rel bit0", qv,   4'b0001, 1'b1, 1'b0, 1'b0);
    ev1(h + 4,  "rel bit1", qv,   4'b0011, 1'b1, 1'b0, 1'b0);
    ev1(h + 8,  "rel bit2", qv,   4'b0111, 1'b1, 1'b0, 1'b0);
    ev1(h + 12, "seq done", 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0);
    if (!retrig) ev1(h + 13, "idle", 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
  endtask

  // Power-on sequence of both DUTs, r = first cycle with sysReset low.
  task automatic push_power_on(int r);
    push_release(r + 16, 1'b0, 1'b0);
    ev2(r + 1, "por done", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    ev2(r + 2, "por idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goto(int c);
    while (cyc < c) @(negedge sysClk);
  endtask

  task automatic soft_pulse();
    softRstReq = 1'b1;
    @(negedge sysClk);
    softRstReq = 1'b0;
  endtask

  task automatic ack_at(int c);
    goto(c);
    quiesceAck = 1'b1;
    goto(c + 1);
    quiesceAck = 1'b0;
  endtask

  // Monitors: every change of the output vector is one DUT event.
  logic [7:0] prev1 = 8'bx;
  logic [7:0] prev2 = 8'bx;

  always @(negedge sysClk) begin : mon4
    logic [7:0] cur;
    ev_t        e;
    cur = pack(quiesceReq, domReset_L, seqBusy, seqDone, timeoutErr);
    if (cur !== prev1) begin
      if (exp1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut4 unexpected change: cycle %0d vec %b, required no change", cyc, cur);
      end else begin
        e = exp1.pop_front();
        check_ev({"dut4 ", e.name}, cyc, cur, e.cyc, e.vec);
      end
      prev1 = cur;
    end
  end

  always @(negedge sysClk) begin : mon1
    logic [7:0] cur;
    ev_t        e;
    cur = pack(qreq2, {3'b000, dom2}, busy2, done2, terr2);
    if (cur !== prev2) begin
      if (exp2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected change: cycle %0d vec %b, required no change", cyc, cur);
      end else begin
        e = exp2.pop_front();
        check_ev({"dut1 ", e.name}, cyc, cur, e.cyc, e.vec);
      end
      prev2 = cur;
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got cycle %0d, required finish before cycle 2000", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    int r;
    sysReset   = 1'b1;
    softRstReq = 1'b0;
    quiesceAck = 1'b0;
    soft2      = 1'b0;
    ack2       = 1'b0;

    // Reset state, visible after the first edge.
    ev1(1, "reset", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    ev2(1, "reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 1. Power-on after 5 reset cycles.
    goto(5);
    sysReset = 1'b0;
    r = cyc;
    push_power_on(r);
    goto(r + 32);

    // 6. Single-domain DUT, HOLD=1, GAP=1, ack at k+2.
    k = cyc;
    ev2(k + 1, "nd1 quiesce", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    ev2(k + 3, "nd1 hold",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ev2(k + 4, "nd1 done",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    ev2(k + 5, "nd1 idle",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    soft2 = 1'b1;
    @(negedge sysClk);
    soft2 = 1'b0;
    goto(k + 2);
    ack2 = 1'b1;
    goto(k + 3);
    ack2 = 1'b0;
    goto(k + 8);

    // 2. Soft reset, ack at k+3.
    k = cyc;
    ev1(k + 1, "quiesce", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    ev1(k + 4, "hold",    1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    push_release(k + 20, 1'b1, 1'b0);
    soft_pulse();
    ack_at(k + 3);
    goto(k + 36);

    // 3. Quiesce timeout: no ack, HOLD forced after 256 QUIESCE cycles.
    k = cyc;
    ev1(k + 1,   "quiesce",      1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    ev1(k + 257, "timeout hold", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    ev1(k + 258, "timeout end",  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    push_release(k + 273, 1'b1, 1'b0);
    soft_pulse();
    goto(k + 290);

    // 4. Request (and a stray ack) while busy: ignored, not queued.
    k = cyc;
    ev1(k + 1, "quiesce", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    ev1(k + 3, "hold",    1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    push_release(k + 19, 1'b1, 1'b0);
    soft_pulse();
    ack_at(k + 2);
    goto(k + 10);
    softRstReq = 1'b1;
    goto(k + 12);
    quiesceAck = 1'b1;
    goto(k + 15);
    quiesceAck = 1'b0;
    goto(k + 29);
    softRstReq = 1'b0;
    goto(k + 36);

    // Request still high in the completion cycle re-triggers a sequence.
    k = cyc;
    ev1(k + 1,  "quiesce",   1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    ev1(k + 3,  "hold",      1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    push_release(k + 19, 1'b1, 1'b1);
    ev1(k + 32, "retrigger", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    ev1(k + 35, "hold2",     1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    push_release(k + 51, 1'b1, 1'b0);
    soft_pulse();
    ack_at(k + 2);
    goto(k + 30);
    softRstReq = 1'b1;
    goto(k + 32);
    softRstReq = 1'b0;
    ack_at(k + 34);
    goto(k + 68);

    // 5. sysReset for one cycle while domReset_L = 0011, then power-on.
    k = cyc;
    ev1(k + 1,  "quiesce",   1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    ev1(k + 3,  "hold",      1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    ev1(k + 19, "rel bit0",  1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    ev1(k + 23, "rel bit1",  1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
    ev1(k + 25, "mid reset", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    ev2(k + 25, "mid reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_power_on(k + 25);
    soft_pulse();
    ack_at(k + 2);
    goto(k + 24);
    sysReset = 1'b1;
    goto(k + 25);
    sysReset = 1'b0;
    goto(k + 25 + 34);

    check_int("dut4 pending events", exp1.size(), 0);
    check_int("dut1 pending events", exp2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
